shift_pattern_sequencer: RTL and testbench
==========================================

Name: shift_pattern_sequencer

Overview:
- Sequences an 8-bit one-hot "walking light" pattern under software-style control: start/stop, selectable sweep mode, programmable per-step dwell, and a fixed extra hold at the home position (bit 0).
- Sits between the board control logic (buttons/switches) and the LED bank.
- Supersedes the free-running shift counter with a startable, stoppable, rate-controlled sequencer that reports its status.

Parameters:
- WIDTH, 8, pattern width; must be >= 2.
- DW, 8, width of dwell configuration and dwell counter.
- END_HOLD, 3, extra ticks the pattern stays at home (bit 0) before each pass; 0 is legal.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin sequencing; honoured only in IDLE.
- stop  input  1  abort request; honoured in any state.
- mode  input  2  sweep mode: 00 bounce, 01 rotate-left, 10 rotate-right, 11 single bounce sweep; sampled on accepted start.
- dwell  input  DW  clocks per step minus 1; sampled on accepted start.
- count  output  WIDTH  registered one-hot pattern.
- busy  output  1  high while sequencing.
- step  output  1  one-cycle pulse, high in the cycle count shows a new value.
- done  output  1  one-cycle pulse at the end of a single sweep.

Behaviour:
- Reset: count=1 (bit 0), busy=0, step=0, done=0, state=IDLE, all counters and latched config 0. All outputs are registered.
- States: IDLE, HOLD, RUN.
- Tick generator, active in HOLD/RUN:
  - dwell_cnt counts 0..dwell_q. tick=1 in the cycle dwell_cnt==dwell_q, then dwell_cnt returns to 0.
  - dwell_q=0 gives a tick every cycle.
  - dwell_cnt clears on entry to HOLD from IDLE.
- IDLE: count=1, busy=0.
  - start=1 and stop=0: latch mode_q/dwell_q, hold_cnt=0, dir=up; next state HOLD, busy=1 from the next cycle.
- HOLD (count=1):
  - Each tick: if hold_cnt==END_HOLD, go to RUN and perform the first move; else hold_cnt++.
  - Bit 0 is therefore shown for END_HOLD+1 ticks.
  - First move: modes 00/01/11 shift left (count=2); mode 10 rotates right (count=MSB).
- RUN, one move per tick:
  - 00 bounce / 11 single:
    - dir=up: shift left; on reaching MSB set dir=down.
    - dir=down: shift right; on reaching bit 0, mode 00 goes to HOLD (hold_cnt=0, dir=up).
    - Mode 11 reaching bit 0 goes to IDLE: done=1 and busy=0 in that same cycle.
  - 01 rotate-left: shift left; MSB wraps to bit 0 and enters HOLD.
  - 10 rotate-right: shift right; on reaching bit 0 enters HOLD.
- step=1 exactly in cycles where count differs from the previous cycle. It is also asserted when count returns to 1 on stop from a non-home position.
- stop: in any state, the next cycle gives IDLE, count=1, busy=0, done=0.
  - stop beats start in the same cycle.
  - stop in IDLE is a no-op.
- start while busy is ignored. mode/dwell changes while busy are ignored.
- reset beats stop and start.
- count is never zero or multi-hot.

Period at dwell=0, END_HOLD=3, WIDTH=8:
- Bounce: 17 cycles (0x01 for 4, 0x02..0x80 for 7, 0x40..0x02 for 6), 14 step pulses.
- Rotate modes: 11 cycles.

Test Plan:
- Reset, no start for 20 cycles -> count=0x01, busy=0, step=0, done=0 throughout.
- Bounce, dwell=0: start pulse -> count 0x01 for 4 cycles, then 0x02,0x04,...,0x80,0x40,...,0x02, then 0x01; pattern repeats every 17 cycles with 14 step pulses per period; done never asserts.
- Bounce, dwell=2 -> each non-home value held 3 cycles, 0x01 held 12 cycles, period 51; changing dwell mid-run has no effect.
- Single sweep (mode 11), dwell=0 -> one pass 0x01..0x80..0x01; done=1 for exactly one cycle when count returns to 0x01, busy falls in the same cycle; a second start repeats the pass.
- Rotate-left and rotate-right, dwell=0 -> 0x01 x4, 0x02..0x80, 0x01 (period 11); and 0x01 x4, 0x80,0x40..0x02, 0x01.
- Stop at count=0x20 -> next cycle count=0x01, busy=0, step=1, done=0. stop+start in the same IDLE cycle -> stays IDLE. reset during RUN -> next cycle reset values; start and reset together -> IDLE.

Source files
------------

// File: rtl/shift_pattern_sequencer_if.sv
// Control/status bundle between board control logic and the walking-light sequencer.
// The master side drives start/stop/config; the sequencer drives the LED pattern and status.
interface shift_pattern_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DW    = 8
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [DW-1:0]    dwell;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             step;
    logic             done;

    modport master (output start, stop, mode, dwell, input count, busy, step, done);
    modport slave  (input start, stop, mode, dwell, output count, busy, step, done);
endinterface

// File: rtl/shift_pattern_sequencer.sv
// One-hot walking-light sequencer with start/stop, four sweep modes, programmable
// per-step dwell and an extra hold at the home position (bit 0).
module shift_pattern_sequencer #(
    parameter int WIDTH    = 8,
    parameter int DW       = 8,
    parameter int END_HOLD = 3
) (
    input logic                    clk,
    input logic                    reset,
    shift_pattern_sequencer_if.slave bus
);
    localparam int HW = (END_HOLD < 1) ? 1 : $clog2(END_HOLD + 1);
    localparam logic [WIDTH-1:0] HOME = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [1:0] M_BOUNCE = 2'b00;
    localparam logic [1:0] M_ROTL   = 2'b01;
    localparam logic [1:0] M_ROTR   = 2'b10;
    localparam logic [1:0] M_SINGLE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_busy;
    logic             r_step;
    logic             r_done;
    logic [1:0]       r_mode_q;
    logic [DW-1:0]    r_dwell_q;
    logic [DW-1:0]    r_dwell_cnt;
    logic [HW-1:0]    r_hold_cnt;
    logic             r_dir;   // 1 = moving toward MSB

    logic             w_tick;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;

    assign w_tick = (r_state != S_IDLE) && (r_dwell_cnt == r_dwell_q);
    assign w_shl  = {r_count[WIDTH-2:0], 1'b0};
    assign w_shr  = {1'b0, r_count[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= HOME;
            r_busy      <= 1'b0;
            r_step      <= 1'b0;
            r_done      <= 1'b0;
            r_mode_q    <= 2'b00;
            r_dwell_q   <= '0;
            r_dwell_cnt <= '0;
            r_hold_cnt  <= '0;
            r_dir       <= 1'b1;
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            if (bus.stop) begin
                // Abort from anywhere; step reports the jump back home if there is one
                r_state     <= S_IDLE;
                r_count     <= HOME;
                r_busy      <= 1'b0;
                r_step      <= (r_count != HOME);
                r_dwell_cnt <= '0;
                r_hold_cnt  <= '0;
                r_dir       <= 1'b1;
            end else begin
                if (r_state != S_IDLE)
                    r_dwell_cnt <= w_tick ? '0 : r_dwell_cnt + 1'b1;
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_mode_q    <= bus.mode;
                            r_dwell_q   <= bus.dwell;
                            r_dwell_cnt <= '0;
                            r_hold_cnt  <= '0;
                            r_dir       <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (w_tick) begin
                            if (r_hold_cnt == HW'(END_HOLD)) begin
                                r_state <= S_RUN;
                                r_step  <= 1'b1;
                                r_count <= (r_mode_q == M_ROTR) ? MSB : WIDTH'(2);
                                // With WIDTH==2 the first left move already lands on the MSB
                                r_dir   <= (WIDTH > 2);
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_tick) begin
                            r_step <= 1'b1;
                            case (r_mode_q)
                                M_ROTL: begin
                                    if (r_count[WIDTH-1]) begin
                                        r_count    <= HOME;
                                        r_hold_cnt <= '0;
                                        r_state    <= S_HOLD;
                                    end else begin
                                        r_count <= w_shl;
                                    end
                                end
                                M_ROTR: begin
                                    r_count <= w_shr;
                                    if (r_count[1]) begin
                                        r_hold_cnt <= '0;
                                        r_state    <= S_HOLD;
                                    end
                                end
                                default: begin
                                    if (r_dir) begin
                                        r_count <= w_shl;
                                        if (r_count[WIDTH-2])
                                            r_dir <= 1'b0;
                                    end else begin
                                        r_count <= w_shr;
                                        if (r_count[1]) begin
                                            r_dir      <= 1'b1;
                                            r_hold_cnt <= '0;
                                            if (r_mode_q == M_SINGLE) begin
                                                r_state <= S_IDLE;
                                                r_busy  <= 1'b0;
                                                r_done  <= 1'b1;
                                            end else begin
                                                r_state <= S_HOLD;
                                            end
                                        end
                                    end
                                end
                            endcase
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.count = r_count;
    assign bus.busy  = r_busy;
    assign bus.step  = r_step;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_shift_pattern_sequencer.sv
// Directed bench for the walking-light sequencer: reset, every sweep mode, dwell,
// stop/start priority and reset during a run, against hand-written pattern tables.
module tb_shift_pattern_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    shift_pattern_sequencer_if #(.WIDTH(8), .DW(8)) bus ();

    shift_pattern_sequencer #(.WIDTH(8), .DW(8), .END_HOLD(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] BNC  [17] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                              8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    logic [7:0] ROTL [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                              8'h40, 8'h80};
    logic [7:0] ROTR [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                              8'h04, 8'h02};

    // Pulse start for one cycle; returns at the first negedge after acceptance
    task automatic start_seq(input logic [1:0] m, input logic [7:0] d);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.dwell = d;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic stop_seq();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.mode  = 2'(i);
            bus.dwell = 8'(i * 7);
            checks++;
            if ({bus.count, bus.busy, bus.step, bus.done} !== {8'h01, 3'b000}) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got count=%h busy=%b step=%b done=%b, want 01/0/0/0",
                         i, bus.count, bus.busy, bus.step, bus.done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bounce_d0();
        logic [7:0] e;
        logic       es;
        int         steps = 0;
        start_seq(2'b00, 8'd0);
        for (int i = 0; i < 34; i++) begin
            e  = BNC[i % 17];
            es = (i == 0) ? 1'b0 : (BNC[i % 17] != BNC[(i + 16) % 17]);
            checks++;
            if (bus.count !== e) begin
                errors++;
                $display("FAIL bounce_d0_count cyc %0d: got %h want %h", i, bus.count, e);
            end
            checks++;
            if (bus.step !== es) begin
                errors++;
                $display("FAIL bounce_d0_step cyc %0d: got %b want %b", i, bus.step, es);
            end
            checks++;
            if ({bus.busy, bus.done} !== 2'b10) begin
                errors++;
                $display("FAIL bounce_d0_status cyc %0d: got busy=%b done=%b want 1/0", i, bus.busy, bus.done);
            end
            if (i >= 17 && bus.step === 1'b1) steps++;
            @(negedge clk);
        end
        checks++;
        if (steps != 14) begin
            errors++;
            $display("FAIL bounce_d0_steps_per_period: got %0d want 14", steps);
        end
        stop_seq();
    endtask

    task automatic test_bounce_d2();
        logic [7:0] e;
        logic [7:0] ep;
        start_seq(2'b00, 8'd2);
        ep = 8'h01;
        for (int i = 0; i < 60; i++) begin
            e = BNC[(i / 3) % 17];
            checks++;
            if (bus.count !== e) begin
                errors++;
                $display("FAIL bounce_d2_count cyc %0d: got %h want %h", i, bus.count, e);
            end
            checks++;
            if (bus.step !== (e != ep)) begin
                errors++;
                $display("FAIL bounce_d2_step cyc %0d: got %b want %b", i, bus.step, e != ep);
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL bounce_d2_busy cyc %0d: got %b want 1", i, bus.busy);
            end
            ep = e;
            // mid-run config changes and a stray start must be ignored
            if (i == 5) bus.dwell = 8'd0;
            if (i == 20) begin bus.start = 1'b1; bus.mode = 2'b01; end
            if (i == 21) bus.start = 1'b0;
            @(negedge clk);
        end
        stop_seq();
    endtask

    task automatic test_single();
        logic [7:0] e;
        logic       es;
        for (int rep = 0; rep < 2; rep++) begin
            start_seq(2'b11, 8'd0);
            for (int i = 0; i < 19; i++) begin
                e  = (i < 17) ? BNC[i] : 8'h01;
                es = (i == 0 || i == 18) ? 1'b0 : (i == 17) ? 1'b1 : (BNC[i] != BNC[i - 1]);
                checks++;
                if (bus.count !== e) begin
                    errors++;
                    $display("FAIL single_count rep %0d cyc %0d: got %h want %h", rep, i, bus.count, e);
                end
                checks++;
                if (bus.step !== es) begin
                    errors++;
                    $display("FAIL single_step rep %0d cyc %0d: got %b want %b", rep, i, bus.step, es);
                end
                checks++;
                if ({bus.busy, bus.done} !== {(i < 17), (i == 17)}) begin
                    errors++;
                    $display("FAIL single_status rep %0d cyc %0d: got busy=%b done=%b want %b/%b",
                             rep, i, bus.busy, bus.done, i < 17, i == 17);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_rotate(input logic [1:0] m);
        logic [7:0] e;
        logic [7:0] ep;
        start_seq(m, 8'd0);
        for (int i = 0; i < 22; i++) begin
            e  = (m == 2'b01) ? ROTL[i % 11] : ROTR[i % 11];
            ep = (m == 2'b01) ? ROTL[(i + 10) % 11] : ROTR[(i + 10) % 11];
            checks++;
            if (bus.count !== e) begin
                errors++;
                $display("FAIL rotate%0d_count cyc %0d: got %h want %h", m, i, bus.count, e);
            end
            checks++;
            if (bus.step !== ((i != 0) && (e != ep))) begin
                errors++;
                $display("FAIL rotate%0d_step cyc %0d: got %b want %b", m, i, bus.step, (i != 0) && (e != ep));
            end
            checks++;
            if ({bus.busy, bus.done} !== 2'b10) begin
                errors++;
                $display("FAIL rotate%0d_status cyc %0d: got busy=%b done=%b want 1/0", m, i, bus.busy, bus.done);
            end
            @(negedge clk);
        end
        stop_seq();
    endtask

    task automatic test_stop();
        start_seq(2'b00, 8'd0);
        repeat (8) @(negedge clk);
        checks++;
        if (bus.count !== 8'h20) begin
            errors++;
            $display("FAIL stop_pre_count: got %h want 20", bus.count);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        checks++;
        if ({bus.count, bus.busy, bus.step, bus.done} !== {8'h01, 3'b010}) begin
            errors++;
            $display("FAIL stop_abort: got count=%h busy=%b step=%b done=%b want 01/0/1/0",
                     bus.count, bus.busy, bus.step, bus.done);
        end
        @(negedge clk);
        checks++;
        if ({bus.count, bus.busy, bus.step, bus.done} !== {8'h01, 3'b000}) begin
            errors++;
            $display("FAIL stop_after: got count=%h busy=%b step=%b done=%b want 01/0/0/0",
                     bus.count, bus.busy, bus.step, bus.done);
        end
    endtask

    task automatic test_stop_start();
        @(negedge clk);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        bus.dwell = 8'd0;
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({bus.count, bus.busy, bus.step, bus.done} !== {8'h01, 3'b000}) begin
                errors++;
                $display("FAIL stop_start_idle cyc %0d: got count=%h busy=%b step=%b done=%b",
                         i, bus.count, bus.busy, bus.step, bus.done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_run();
        start_seq(2'b01, 8'd0);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.count !== 8'h08) begin
            errors++;
            $display("FAIL reset_run_pre: got %h want 08", bus.count);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.count, bus.busy, bus.step, bus.done} !== {8'h01, 3'b000}) begin
            errors++;
            $display("FAIL reset_run_abort: got count=%h busy=%b step=%b done=%b want 01/0/0/0",
                     bus.count, bus.busy, bus.step, bus.done);
        end
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({bus.count, bus.busy} !== {8'h01, 1'b0}) begin
                errors++;
                $display("FAIL reset_start_idle cyc %0d: got count=%h busy=%b want 01/0", i, bus.count, bus.busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 2'b00;
        bus.dwell = 8'd0;
        test_reset();
        test_bounce_d0();
        test_bounce_d2();
        test_single();
        test_rotate(2'b01);
        test_rotate(2'b10);
        test_stop();
        test_stop_start();
        test_reset_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
